// File: rtl/rb_param.sv
// Parametrised register bank: one write port, two read ports, optional hard-zero r0,
// optional registered reads, write-to-read bypass and a sequenced bulk clear.
module rb_param #(
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned ZERO_R0 = 0,
  parameter int unsigned REG_OUT = 0,
  parameter int unsigned BYPASS  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   d_in,
  input  logic            rw_in,
  input  logic [3*AW-1:0] rs_in,
  input  logic            clr_in,
  output logic [DW-1:0]   a_out,
  output logic [DW-1:0]   b_out,
  output logic            busy_out
);

  localparam int unsigned Depth = 2 ** AW;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   mem_q [Depth];

  logic [AW-1:0]   wsel, asel, bsel;
  logic            wr_en, clr_en;
  logic            fwd_a, fwd_b;
  logic [DW-1:0]   rd_a, rd_b;
  logic [DW-1:0]   a_val, b_val;

  assign wsel = rs_in[3*AW-1:2*AW];
  assign asel = rs_in[2*AW-1:AW];
  assign bsel = rs_in[AW-1:0];

  // A write to hard-zero r0 is dropped entirely, so it must not be forwarded either.
  assign wr_en = rw_in && (state_q == StIdle) && !((ZERO_R0 != 0) && (wsel == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_in) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write and sweep never coincide: writes are only accepted in StIdle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_q[wsel] <= d_in;
      end
      if (clr_en) begin
        mem_q[cnt_q] <= '0;
      end
    end
  end

  always_comb begin
    rd_a  = ((ZERO_R0 != 0) && (asel == '0)) ? '0 : mem_q[asel];
    rd_b  = ((ZERO_R0 != 0) && (bsel == '0)) ? '0 : mem_q[bsel];
    fwd_a = (BYPASS != 0) && wr_en && (asel == wsel);
    fwd_b = (BYPASS != 0) && wr_en && (bsel == wsel);
    a_val = fwd_a ? d_in : rd_a;
    b_val = fwd_b ? d_in : rd_b;
  end

  // With BYPASS=0 a_val equals the pre-edge contents, giving read-first capture.
  if (REG_OUT != 0) begin : g_reg_out
    logic [DW-1:0] a_q, b_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        a_q <= '0;
        b_q <= '0;
      end else begin
        a_q <= a_val;
        b_q <= b_val;
      end
    end

    assign a_out = a_q;
    assign b_out = b_q;
  end else begin : g_comb_out
    assign a_out = a_val;
    assign b_out = b_val;
  end

  assign busy_out = (state_q == StClear);

endmodule

// File: tb/tb_rb_param.sv
// Directed bench for rb_param: five parameter variants share one stimulus stream.
module tb_rb_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_in;
  logic        rw_in;
  logic [11:0] rs_in;
  logic        clr_in;

  logic [15:0] a_def, b_def, a_nb, b_nb, a_z, b_z, a_rf, b_rf, a_rw, b_rw;
  logic        busy_def, busy_nb, busy_z, busy_rf, busy_rw;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rb_param #(.DW(16), .AW(4), .ZERO_R0(0), .REG_OUT(0), .BYPASS(1)) u_def (
    .clk(clk), .rst(rst), .d_in(d_in), .rw_in(rw_in), .rs_in(rs_in), .clr_in(clr_in),
    .a_out(a_def), .b_out(b_def), .busy_out(busy_def)
  );
  rb_param #(.DW(16), .AW(4), .ZERO_R0(0), .REG_OUT(0), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .d_in(d_in), .rw_in(rw_in), .rs_in(rs_in), .clr_in(clr_in),
    .a_out(a_nb), .b_out(b_nb), .busy_out(busy_nb)
  );
  rb_param #(.DW(16), .AW(4), .ZERO_R0(1), .REG_OUT(0), .BYPASS(1)) u_z (
    .clk(clk), .rst(rst), .d_in(d_in), .rw_in(rw_in), .rs_in(rs_in), .clr_in(clr_in),
    .a_out(a_z), .b_out(b_z), .busy_out(busy_z)
  );
  rb_param #(.DW(16), .AW(4), .ZERO_R0(0), .REG_OUT(1), .BYPASS(0)) u_rf (
    .clk(clk), .rst(rst), .d_in(d_in), .rw_in(rw_in), .rs_in(rs_in), .clr_in(clr_in),
    .a_out(a_rf), .b_out(b_rf), .busy_out(busy_rf)
  );
  rb_param #(.DW(16), .AW(4), .ZERO_R0(0), .REG_OUT(1), .BYPASS(1)) u_rw (
    .clk(clk), .rst(rst), .d_in(d_in), .rw_in(rw_in), .rs_in(rs_in), .clr_in(clr_in),
    .a_out(a_rw), .b_out(b_rw), .busy_out(busy_rw)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [3:0] w, input logic [3:0] a,
                       input logic [3:0] b, input logic [15:0] d, input logic clr);
    rw_in  = rw;
    rs_in  = {w, a, b};
    d_in   = d;
    clr_in = clr;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    #1;
    chk("rst_busy", {15'd0, busy_def}, 16'd0);
    chk("rst_rf_a", a_rf, 16'h0000);
    chk("rst_rw_b", b_rw, 16'h0000);
    drive(1'b0, 4'd0, 4'd3, 4'd7, 16'h0000, 1'b0);
    #1;
    chk("rst_def_a", a_def, 16'h0000);

    // Test 1: basic writes and reads
    drive(1'b1, 4'd3, 4'd0, 4'd0, 16'hA5A5, 1'b0);
    tick();
    drive(1'b1, 4'd7, 4'd0, 4'd0, 16'h1234, 1'b0);
    tick();
    drive(1'b0, 4'd0, 4'd3, 4'd7, 16'h0000, 1'b0);
    #1;
    chk("t1_def_a", a_def, 16'hA5A5);
    chk("t1_def_b", b_def, 16'h1234);
    chk("t1_nb_a", a_nb, 16'hA5A5);
    tick();
    chk("t1_rf_a", a_rf, 16'hA5A5);
    chk("t1_rw_b", b_rw, 16'h1234);
    for (int i = 0; i < 16; i++) begin
      if (i != 3 && i != 7) begin
        drive(1'b0, 4'd0, 4'(i), 4'd0, 16'h0000, 1'b0);
        #1;
        chk("t1_other_zero", a_def, 16'h0000);
      end
    end

    // Test 2: same-cycle bypass vs. no bypass
    drive(1'b1, 4'd5, 4'd5, 4'd5, 16'hBEEF, 1'b0);
    #1;
    chk("t2_byp_a", a_def, 16'hBEEF);
    chk("t2_byp_b", b_def, 16'hBEEF);
    chk("t2_nobyp_a", a_nb, 16'h0000);
    chk("t2_nobyp_b", b_nb, 16'h0000);
    tick();
    chk("t2_rw_cap", a_rw, 16'hBEEF);
    chk("t2_rf_cap", a_rf, 16'h0000);
    drive(1'b0, 4'd5, 4'd5, 4'd5, 16'h0000, 1'b0);
    #1;
    chk("t2_def_after", a_def, 16'hBEEF);
    chk("t2_nb_after", a_nb, 16'hBEEF);

    // Test 3: hard-zero r0
    drive(1'b1, 4'd0, 4'd0, 4'd1, 16'hFFFF, 1'b0);
    #1;
    chk("t3_z_r0_before", a_z, 16'h0000);
    chk("t3_def_r0_byp", a_def, 16'hFFFF);
    tick();
    drive(1'b0, 4'd0, 4'd0, 4'd1, 16'h0000, 1'b0);
    #1;
    chk("t3_z_r0_after", a_z, 16'h0000);
    chk("t3_def_r0_after", a_def, 16'hFFFF);
    drive(1'b1, 4'd1, 4'd1, 4'd0, 16'hFFFF, 1'b0);
    #1;
    chk("t3_z_r1_byp", a_z, 16'hFFFF);
    tick();
    drive(1'b0, 4'd0, 4'd1, 4'd0, 16'h0000, 1'b0);
    #1;
    chk("t3_z_r1_after", a_z, 16'hFFFF);

    // Test 4: registered outputs, read-first vs. write-first
    drive(1'b1, 4'd2, 4'd2, 4'd0, 16'h0011, 1'b0);
    tick();
    drive(1'b1, 4'd2, 4'd2, 4'd0, 16'h0022, 1'b0);
    tick();
    chk("t4_rf_readfirst", a_rf, 16'h0011);
    chk("t4_rw_writefirst", a_rw, 16'h0022);
    drive(1'b0, 4'd0, 4'd2, 4'd0, 16'h0000, 1'b0);
    tick();
    chk("t4_rf_next", a_rf, 16'h0022);

    // Test 5: bulk clear
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 4'd0, 4'd0, 16'h1000 + 16'(i), 1'b0);
      tick();
    end
    drive(1'b1, 4'd9, 4'd9, 4'd10, 16'h7777, 1'b1);
    tick();
    for (int k = 0; k < 16; k++) begin
      // Write to r10 held active throughout; it must be ignored while busy.
      drive(1'b1, 4'd10, 4'd9, 4'd10, 16'hBBBB, (k == 3) ? 1'b1 : 1'b0);
      #1;
      chk("t5_busy", {15'd0, busy_def}, 16'd1);
      chk("t5_r9", a_def, (k <= 9) ? 16'h7777 : 16'h0000);
      chk("t5_r10", b_def, (k <= 10) ? 16'h100A : 16'h0000);
      if (k == 5) begin
        drive(1'b1, 4'd10, 4'd12, 4'd2, 16'hBBBB, 1'b0);
        #1;
        chk("t5_mid_r12", a_def, 16'h100C);
        chk("t5_mid_r2", b_def, 16'h0000);
      end
      tick();
    end
    drive(1'b0, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0);
    #1;
    chk("t5_busy_fall", {15'd0, busy_def}, 16'd0);
    chk("t5_busy_fall_nb", {15'd0, busy_nb}, 16'd0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'd0, 4'(i), 4'(15 - i), 16'h0000, 1'b0);
      #1;
      chk("t5_cleared_a", a_def, 16'h0000);
      chk("t5_cleared_b", b_nb, 16'h0000);
    end

    // Test 6: reset in the middle of a clear
    drive(1'b1, 4'd13, 4'd13, 4'd0, 16'hDDDD, 1'b0);
    tick();
    drive(1'b0, 4'd0, 4'd13, 4'd0, 16'h0000, 1'b1);
    tick();
    clr_in = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("t6_busy_mid", {15'd0, busy_def}, 16'd1);
    chk("t6_r13_mid", a_def, 16'hDDDD);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_busy_after_rst", {15'd0, busy_def}, 16'd0);
    chk("t6_r13_after_rst", a_def, 16'h0000);
    drive(1'b1, 4'd14, 4'd14, 4'd13, 16'hE14E, 1'b0);
    tick();
    drive(1'b0, 4'd0, 4'd14, 4'd13, 16'h0000, 1'b0);
    #1;
    chk("t6_busy_idle", {15'd0, busy_def}, 16'd0);
    chk("t6_r14_write", a_def, 16'hE14E);
    tick();
    chk("t6_r14_kept", a_def, 16'hE14E);
    for (int i = 0; i < 16; i++) begin
      if (i != 14) begin
        drive(1'b0, 4'd0, 4'(i), 4'd0, 16'h0000, 1'b0);
        #1;
        chk("t6_zero", a_def, 16'h0000);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
